// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of an asynchronous FIFO.
// Synchronizes the write Gray pointer, keeps the read pointer and empty /
// fill-level flags, issues memory reads, and feeds a 3-entry output buffer
// that absorbs the one-cycle memory latency so downstream backpressure
// never reaches the memory read strobe combinationally.
//
// Downstream handshake: m_valid/m_data present the oldest buffered word;
// a word transfers on any rising r_clk edge where m_valid & m_ready are
// both high. Once m_valid rises it stays high, with m_data unchanged,
// until that transfer happens.
module fifo_rd_ctrl #(
   parameter int data_width = 8,
   parameter int addr_width = 5
) (
   input  logic                  r_clk,
   input  logic                  arstn,
   input  logic [addr_width:0]   w_ptr_gray,
   output logic [addr_width:0]   r_ptr_gray,
   output logic                  mem_r_en,
   output logic [addr_width-1:0] mem_r_addr,
   input  logic [data_width-1:0] mem_rdata,
   output logic                  empty,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [data_width-1:0] m_data,
   output logic [addr_width:0]   rd_count
);

   localparam int PW = addr_width + 1;

   logic [PW-1:0]         wq1_q, wq2_q;
   logic [PW-1:0]         wbin_s;
   logic [PW-1:0]         rbin_q, rbin_d;
   logic [PW-1:0]         rgray_q, rgray_d;
   logic [PW-1:0]         rd_count_q, rd_count_d;
   logic                  empty_q, empty_d;
   logic                  inflight_q;
   logic                  pop;
   logic [2:0]            pend;
   logic [1:0]            occ_q, occ_d;
   logic [1:0]            wr_idx;
   logic                  hs;
   logic [data_width-1:0] buf_q [3];
   logic [data_width-1:0] buf_d [3];

   // Two-flop synchronizer: the only logic that samples w_ptr_gray.
   always_ff @(posedge r_clk or negedge arstn) begin
      if (!arstn) begin
         wq1_q <= '0;
         wq2_q <= '0;
      end else begin
         wq1_q <= w_ptr_gray;
         wq2_q <= wq1_q;
      end
   end

   // Gray-to-binary of the synchronized write pointer: bit i is the XOR of bits i and above.
   always_comb begin
      wbin_s = '0;
      for (int i = 0; i < PW; i++) begin
         wbin_s[i] = ^(wq2_q >> i);
      end
   end

   // Pop only while words exist and the buffer has room for everything already requested.
   assign pend = {1'b0, occ_q} + {2'b00, inflight_q};
   assign pop  = ~empty_q & (pend < 3'd3);

   // Next read pointer and the flags derived from it.
   always_comb begin
      rbin_d     = rbin_q + {{(PW-1){1'b0}}, pop};
      rgray_d    = rbin_d ^ (rbin_d >> 1);
      empty_d    = (rgray_d == wq2_q);
      rd_count_d = wbin_s - rbin_d;
   end

   // Read pointer, flags and the one-cycle memory-latency tracker.
   always_ff @(posedge r_clk or negedge arstn) begin
      if (!arstn) begin
         rbin_q     <= '0;
         rgray_q    <= '0;
         empty_q    <= 1'b1;
         rd_count_q <= '0;
         inflight_q <= 1'b0;
      end else begin
         rbin_q     <= rbin_d;
         rgray_q    <= rgray_d;
         empty_q    <= empty_d;
         rd_count_q <= rd_count_d;
         inflight_q <= pop;
      end
   end

   assign hs = m_valid & m_ready;

   // Output buffer: head at index 0, shift on handshake, returning data appended behind the last valid entry.
   always_comb begin
      buf_d[0] = buf_q[0];
      buf_d[1] = buf_q[1];
      buf_d[2] = buf_q[2];
      wr_idx   = occ_q - {1'b0, hs};
      if (hs) begin
         buf_d[0] = buf_q[1];
         buf_d[1] = buf_q[2];
      end
      if (inflight_q) begin
         case (wr_idx)
            2'd0:    buf_d[0] = mem_rdata;
            2'd1:    buf_d[1] = mem_rdata;
            2'd2:    buf_d[2] = mem_rdata;
            default: ;
         endcase
      end
      occ_d = occ_q + {1'b0, inflight_q} - {1'b0, hs};
   end

   // Output buffer storage and occupancy.
   always_ff @(posedge r_clk or negedge arstn) begin
      if (!arstn) begin
         occ_q <= '0;
         for (int i = 0; i < 3; i++) begin
            buf_q[i] <= '0;
         end
      end else begin
         occ_q <= occ_d;
         for (int i = 0; i < 3; i++) begin
            buf_q[i] <= buf_d[i];
         end
      end
   end

   assign r_ptr_gray = rgray_q;
   assign mem_r_en   = pop;
   assign mem_r_addr = rbin_q[addr_width-1:0];
   assign empty      = empty_q;
   assign m_valid    = (occ_q != 2'd0);
   assign m_data     = buf_q[0];
   assign rd_count   = rd_count_q;

endmodule

// File: doc/fifo_rd_ctrl.md
FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 The block SHALL have parameter data_width, default 8, meaning the FIFO word width in bits.
REQ-002 The block SHALL have parameter addr_width, default 5, meaning memory address bits; pointers are addr_width+1 bits and FIFO depth is 2**addr_width.
REQ-003 The block SHALL have port r_clk, input, 1 bit: the single read-domain clock; all flops rise on it.
REQ-004 The block SHALL have port arstn, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port w_ptr_gray, input, addr_width+1 bits: the write-domain Gray pointer, asynchronous to r_clk.
REQ-006 The block SHALL have port r_ptr_gray, output, addr_width+1 bits: registered Gray read pointer, for sync into the write domain.
REQ-007 The block SHALL have port mem_r_en, output, 1 bit: memory read strobe; one pop per cycle high.
REQ-008 The block SHALL have port mem_r_addr, output, addr_width bits: memory read address, equal to rbin[addr_width-1:0].
REQ-009 The block SHALL have port mem_rdata, input, data_width bits: memory read data, valid the cycle after mem_r_en.
REQ-010 The block SHALL have port empty, output, 1 bit: registered empty flag, also driven to the memory's empty input.
REQ-011 The block SHALL have port m_valid, output, 1 bit: downstream data valid.
REQ-012 The block SHALL have port m_ready, input, 1 bit: downstream accept.
REQ-013 The block SHALL have port m_data, output, data_width bits: downstream data, the head of the output buffer.
REQ-014 The block SHALL have port rd_count, output, addr_width+1 bits: registered fill level as seen by the read side.

Function
REQ-015 w_ptr_gray SHALL pass through a 2-flop synchronizer (wq1, wq2); no other logic SHALL sample w_ptr_gray.
REQ-016 wq2 SHALL be converted to binary wbin_s combinationally from wq2 only.
REQ-017 pop SHALL equal mem_r_en = ~empty & ((occ + inflight) < 3); occ = output buffer entries (0..3), inflight = pop registered by one cycle. There SHALL be no combinational path from m_ready to mem_r_en.
REQ-018 On pop, rbin SHALL increment by 1 modulo 2**(addr_width+1); r_ptr_gray SHALL register gray(rbin_next) = rbin_next ^ (rbin_next >> 1).
REQ-019 empty SHALL register (gray(rbin_next) == wq2) every cycle.
REQ-020 rd_count SHALL register (wbin_s - rbin_next) modulo 2**(addr_width+1); its maximum legal value is 2**addr_width.
REQ-021 When inflight is 1, mem_rdata SHALL be written into the output buffer (3-entry FIFO, in order) at that clock edge.
REQ-022 m_valid SHALL equal (occ != 0); m_data SHALL be the oldest entry; a handshake is m_valid & m_ready and removes that entry.
REQ-023 While m_valid is high and m_ready is low, m_data and m_valid SHALL hold stable.
REQ-024 A simultaneous buffer write and handshake in one cycle SHALL leave occ unchanged and preserve order.
REQ-025 Buffer overflow (occ+inflight > 3) SHALL be impossible; the bench asserts it.
REQ-026 Pointer wrap SHALL be seamless: mem_r_addr goes 2**addr_width-1 -> 0, and the rbin MSB toggles.
REQ-027 Latency SHALL be: w_ptr_gray change -> empty low = 3 edges; pop -> m_valid = 2 edges; steady m_ready=1 throughput = 1 word per cycle.

Reset
REQ-028 arstn low SHALL immediately clear wq1, wq2, rbin, r_ptr_gray, inflight, occ, rd_count and buffer contents to 0, and set empty=1; m_valid=0 and mem_r_en=0 while arstn is low.
REQ-029 Reset mid-operation SHALL discard buffered and in-flight words; no pop SHALL occur after release until wq2 differs from r_ptr_gray.

Verification
REQ-030 Reset scenario: arstn=0 -> empty=1, m_valid=0, mem_r_en=0, r_ptr_gray=0, rd_count=0.
REQ-031 Single word: w_ptr_gray 0->1, m_ready=1 -> mem_r_en=1 with mem_r_addr=0 after the 3rd edge, r_ptr_gray=1, m_valid=1 two edges later with m_data=word0, empty=1 again.
REQ-032 Backpressure: 8 words written, m_ready=0 -> exactly 3 pops, rd_count=5, m_data=word0 held stable; release m_ready -> words 0..7 delivered in order with no gaps after restart.
REQ-033 Wrap: 70 words streamed with addr_width=5 -> mem_r_addr sequence 31->0 observed, r_ptr_gray returns to 0 after 64 pops, data order intact.
REQ-034 Mid-burst reset: arstn pulsed low with occ=2, inflight=1 -> m_valid falls asynchronously; after release, no pop until a new w_ptr_gray value arrives.
REQ-035 Random m_ready at 50% over 500 words -> no drop, no duplicate, no overflow assertion, and empty=1 at drain end.
